// File: rtl/fb_capture_ctrl_pkg.sv
// Shared constants for the 80x60 RGB444 frame buffer write and read paths.
package fb_capture_ctrl_pkg;

  localparam int unsigned c_img_cols    = 80;
  localparam int unsigned c_img_rows    = 60;
  localparam int unsigned c_img_pxls    = c_img_cols * c_img_rows;
  localparam int unsigned c_nb_img_pxls = 13;

  localparam int unsigned c_nb_buf_red   = 4;
  localparam int unsigned c_nb_buf_green = 4;
  localparam int unsigned c_nb_buf_blue  = 4;
  localparam int unsigned c_nb_buf       = c_nb_buf_red + c_nb_buf_green + c_nb_buf_blue;

endpackage

// File: rtl/cam_sync_edge.sv
// Registers camera vsync/href once and flags their edges against the registered copy.
module cam_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vsync_i,
  input  logic href_i,
  output logic href_o,
  output logic vsync_rise_o,
  output logic vsync_fall_o,
  output logic href_rise_o,
  output logic href_fall_o
);

  logic vsync_q;
  logic href_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
      href_q  <= href_i;
    end
  end

  // Edge strobes fire in the cycle the input differs from its registered copy, so
  // the line is still seen as active (href_o=1) during its own falling-edge cycle.
  always_comb begin
    href_o       = href_q;
    vsync_rise_o = vsync_i & ~vsync_q;
    vsync_fall_o = ~vsync_i & vsync_q;
    href_rise_o  = href_i & ~href_q;
    href_fall_o  = ~href_i & href_q;
  end

endmodule

// File: rtl/fb_capture_ctrl.sv
// Frame buffer write sequencer: arms on request, captures one or every frame from
// the camera stream into linear addresses 0..c_img_pxls-1.
module fb_capture_ctrl
  import fb_capture_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cam_vsync,
  input  logic                     cam_href,
  input  logic                     cam_pxl_vld,
  input  logic [c_nb_buf-1:0]      cam_pxl,
  input  logic                     cont,
  input  logic                     cap_req,
  output logic                     cap_busy,
  output logic                     frame_done,
  output logic                     frame_err,
  output logic                     fb_wea,
  output logic [c_nb_img_pxls-1:0] fb_addra,
  output logic [c_nb_buf-1:0]      fb_dina,
  output logic [7:0]               frame_cnt
);

  typedef enum logic [1:0] {StIdle, StArmed, StCapture} state_e;

  localparam int unsigned NbCol = 7;
  localparam int unsigned NbRow = 6;
  localparam logic [NbCol-1:0]         ColEnd   = NbCol'(c_img_cols);
  localparam logic [NbCol-1:0]         ColSat   = NbCol'(c_img_cols + 1);
  localparam logic [NbRow-1:0]         RowEnd   = NbRow'(c_img_rows);
  localparam logic [NbRow-1:0]         RowSat   = NbRow'(c_img_rows + 1);
  localparam logic [c_nb_img_pxls-1:0] AddrLast = c_nb_img_pxls'(c_img_pxls - 1);

  logic href_q, vsync_rise, vsync_fall, href_rise, href_fall;

  cam_sync_edge u_sync (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .vsync_i      (cam_vsync),
    .href_i       (cam_href),
    .href_o       (href_q),
    .vsync_rise_o (vsync_rise),
    .vsync_fall_o (vsync_fall),
    .href_rise_o  (href_rise),
    .href_fall_o  (href_fall)
  );

  state_e                   state_q;
  logic [NbCol-1:0]         col_q, col_d;
  logic [NbRow-1:0]         row_q, row_d;
  logic [c_nb_img_pxls-1:0] addr_q;
  logic                     line_err_q, ovr_q;
  logic                     cap_busy_q, frame_done_q, frame_err_q, fb_wea_q;
  logic [c_nb_img_pxls-1:0] fb_addra_q;
  logic [c_nb_buf-1:0]      fb_dina_q;
  logic [7:0]               frame_cnt_q;

  logic pix_vld, pix_wr, pix_ovr, line_bad, frame_bad;

  always_comb begin
    pix_vld = (state_q == StCapture) && cam_pxl_vld && href_q;
    pix_wr  = pix_vld && (col_q < ColEnd) && (row_q < RowEnd);
    pix_ovr = pix_vld && !((col_q < ColEnd) && (row_q < RowEnd));
    col_d   = col_q;
    if (pix_vld && (col_q != ColSat)) col_d = col_q + 1'b1;
    // col_d already includes a pixel landing on the href falling-edge cycle
    line_bad = href_fall && (col_d != ColEnd);
    row_d    = row_q;
    if (href_fall && (row_q != RowSat)) row_d = row_q + 1'b1;
    frame_bad = (row_d != RowEnd) || line_err_q || line_bad || ovr_q || pix_ovr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      line_err_q   <= 1'b0;
      ovr_q        <= 1'b0;
      cap_busy_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      fb_wea_q     <= 1'b0;
      fb_addra_q   <= '0;
      fb_dina_q    <= '0;
      frame_cnt_q  <= '0;
    end else begin
      fb_wea_q     <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cap_req || cont) begin
            state_q     <= StArmed;
            cap_busy_q  <= 1'b1;
            frame_err_q <= 1'b0;
          end
        end
        StArmed: begin
          if (vsync_fall) begin
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            line_err_q <= 1'b0;
            ovr_q      <= 1'b0;
            state_q    <= StCapture;
          end
        end
        StCapture: begin
          if (pix_wr) begin
            fb_wea_q   <= 1'b1;
            fb_addra_q <= addr_q;
            fb_dina_q  <= cam_pxl;
            if (addr_q != AddrLast) addr_q <= addr_q + 1'b1;
          end
          if (pix_ovr)  ovr_q      <= 1'b1;
          if (line_bad) line_err_q <= 1'b1;
          if (href_fall) begin
            col_q <= '0;
            row_q <= row_d;
          end else if (href_rise) begin
            col_q <= '0;
          end else begin
            col_q <= col_d;
          end
          if (vsync_rise) begin
            frame_err_q  <= frame_bad;
            frame_done_q <= 1'b1;
            frame_cnt_q  <= frame_cnt_q + 8'd1;
            if (cont) begin
              state_q <= StArmed;
            end else begin
              state_q    <= StIdle;
              cap_busy_q <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    cap_busy   = cap_busy_q;
    frame_done = frame_done_q;
    frame_err  = frame_err_q;
    fb_wea     = fb_wea_q;
    fb_addra   = fb_addra_q;
    fb_dina    = fb_dina_q;
    frame_cnt  = frame_cnt_q;
  end

endmodule

// File: tb/tb_fb_capture_ctrl.sv
// Directed frame scenarios with random pixel data and strobe gaps, checked against
// a raster-position model of which pixels land at which buffer address.
module tb_fb_capture_ctrl;
  import fb_capture_ctrl_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     cam_vsync = 1'b0, cam_href = 1'b0, cam_pxl_vld = 1'b0;
  logic [c_nb_buf-1:0]      cam_pxl = '0;
  logic                     cont = 1'b0, cap_req = 1'b0;
  logic                     cap_busy, frame_done, frame_err, fb_wea;
  logic [c_nb_img_pxls-1:0] fb_addra;
  logic [c_nb_buf-1:0]      fb_dina;
  logic [7:0]               frame_cnt;

  fb_capture_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_pxl_vld (cam_pxl_vld),
    .cam_pxl     (cam_pxl),
    .cont        (cont),
    .cap_req     (cap_req),
    .cap_busy    (cap_busy),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .fb_wea      (fb_wea),
    .fb_addra    (fb_addra),
    .fb_dina     (fb_dina),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned              cyc;
    logic [c_nb_img_pxls-1:0] a;
    logic [c_nb_buf-1:0]      d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         w;
  int unsigned cyc = 0;
  int          checks = 0, failures = 0;
  int          done_seen = 0, exp_done = 0, exp_cnt = 0;
  logic        err_at_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are all registered, so sampling on the falling edge is race-free.
  always @(negedge clk) begin
    if (fb_wea === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL spurious_write: observed addr=%0d expected=no write", fb_addra);
      end
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        checks += 3;
        assert (cyc === w.cyc) else begin
          failures++;
          $error("FAIL wr_latency: observed cyc=%0d expected=%0d", cyc, w.cyc);
        end
        assert (fb_addra === w.a) else begin
          failures++;
          $error("FAIL wr_addr: observed=%0d expected=%0d", fb_addra, w.a);
        end
        assert (fb_dina === w.d) else begin
          failures++;
          $error("FAIL wr_data: observed=%0h expected=%0h", fb_dina, w.d);
        end
      end
    end else if (exp_q.size() != 0) begin
      if (exp_q[0].cyc <= cyc) begin
        checks++;
        failures++;
        $error("FAIL missing_write: observed=no write expected addr=%0d", exp_q[0].a);
        void'(exp_q.pop_front());
      end
    end
    if (frame_done === 1'b1) begin
      done_seen++;
      err_at_done = frame_err;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(cap_busy), 0);
    chk({tag, "_done"}, 32'(frame_done), 0);
    chk({tag, "_err"}, 32'(frame_err), 0);
    chk({tag, "_wea"}, 32'(fb_wea), 0);
    chk({tag, "_addra"}, 32'(fb_addra), 0);
    chk({tag, "_dina"}, 32'(fb_dina), 0);
    chk({tag, "_cnt"}, 32'(frame_cnt), 0);
  endtask

  // One camera frame. Pixels at raster (l,p) inside the window map to l*cols+p.
  task automatic send_frame(input int lines, input int ppl, input bit capt,
                            input int arm_line, input int cont_off_line, input int rst_pix);
    bit cap = capt;
    bit rst_done;
    int pix_idx = 0;
    bit same;
    @(negedge clk);
    cam_vsync = 1'b1;
    repeat (4) @(negedge clk);
    cam_vsync = 1'b0;
    repeat (3) @(negedge clk);
    for (int l = 0; l < lines; l++) begin
      if (l == arm_line) begin
        cap_req = 1'b1;
        cap = 1'b0;
      end
      if (l == arm_line + 1) cap_req = 1'b0;
      if (l == cont_off_line) cont = 1'b0;
      cam_href = 1'b1;
      @(negedge clk);
      same = 1'($urandom_range(0, 1));
      for (int p = 0; p < ppl; p++) begin
        rst_done = 1'b0;
        cam_pxl_vld = 1'b1;
        cam_pxl = 12'($urandom);
        if (p == ppl - 1 && same) cam_href = 1'b0;
        if (cap && l < int'(c_img_rows) && p < int'(c_img_cols))
          exp_q.push_back('{cyc + 1, 13'(l * int'(c_img_cols) + p), cam_pxl});
        if (pix_idx == rst_pix) begin
          @(posedge clk);
          #2;
          rst_n = 1'b0;
          exp_q.delete();
          #1;
          chk_zero("async_rst");
          cap = 1'b0;
          rst_done = 1'b1;
        end
        pix_idx++;
        @(negedge clk);
        if (rst_done) rst_n = 1'b1;
        cam_pxl_vld = 1'b0;
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      if (cam_href) begin
        cam_href = 1'b0;
        @(negedge clk);
      end
      repeat (2) @(negedge clk);
    end
    cam_vsync = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end(input string tag, input bit exp_err);
    exp_done++;
    exp_cnt = (exp_cnt + 1) % 256;
    chk({tag, "_done_pulses"}, 32'(done_seen), 32'(exp_done));
    chk({tag, "_err"}, 32'(err_at_done), 32'(exp_err));
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 0);
  endtask

  task automatic request();
    cap_req = 1'b1;
    @(negedge clk);
    cap_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single-shot nominal frame
    request();
    chk("accept_busy", 32'(cap_busy), 1);
    send_frame(60, 80, 1'b1, -1, -1, -1);
    frame_end("nominal", 1'b0);
    chk("nominal_busy_after", 32'(cap_busy), 0);

    // Arm during line 30: the rest of that frame is ignored, the next one captured
    send_frame(60, 80, 1'b0, 30, -1, -1);
    chk("midarm_busy", 32'(cap_busy), 1);
    chk("midarm_no_done", 32'(done_seen), 32'(exp_done));
    send_frame(60, 80, 1'b1, -1, -1, -1);
    frame_end("midarm", 1'b0);

    // 84-pixel lines: pixels 80..83 dropped, frame flagged
    request();
    send_frame(60, 84, 1'b1, -1, -1, -1);
    frame_end("long_lines", 1'b1);

    // 59-line frame, then a good frame clears the sticky error at accept
    request();
    send_frame(59, 80, 1'b1, -1, -1, -1);
    frame_end("short_frame", 1'b1);
    cap_req = 1'b1;
    @(negedge clk);
    cap_req = 1'b0;
    chk("err_clear_at_accept", 32'(frame_err), 0);
    send_frame(60, 80, 1'b1, -1, -1, -1);
    frame_end("after_short", 1'b0);

    // Continuous mode, dropped during frame 3
    cont = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(60, 80, 1'b1, -1, -1, -1);
    frame_end("cont1", 1'b0);
    chk("cont1_busy", 32'(cap_busy), 1);
    send_frame(60, 80, 1'b1, -1, -1, -1);
    frame_end("cont2", 1'b0);
    send_frame(60, 80, 1'b1, -1, 10, -1);
    frame_end("cont3", 1'b0);
    chk("cont_idle_busy", 32'(cap_busy), 0);

    // Reset during pixel 2000, then resume on the next vsync falling edge
    cont = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(60, 80, 1'b1, -1, -1, 2000);
    exp_cnt = 0;
    chk("rst_no_done", 32'(done_seen), 32'(exp_done));
    chk("rst_busy_rearmed", 32'(cap_busy), 1);
    chk("rst_cnt", 32'(frame_cnt), 0);
    send_frame(60, 80, 1'b1, -1, 5, -1);
    frame_end("post_rst", 1'b0);
    chk("post_rst_busy", 32'(cap_busy), 0);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
